// File: rtl/vblank_arbiter_pkg.sv
// Shared constants for the frame-update arbiter: display timing (vga_pkg)
// and arbiter types/defaults (arb_pkg).
package vga_pkg;
   localparam int VBLNK_END = 806;
endpackage

package arb_pkg;
   localparam int NUM_REQ_DFLT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARB   = 2'd1,
      GRANT = 2'd2
   } arb_state_t;
endpackage

// File: rtl/vblank_arbiter_if.sv
// Bus between the vblank arbiter and its requesters/timing source.
// master = requester/timing side, slave = arbiter side.
interface vblank_arbiter_if #(
   parameter int NUM_REQ = 4
) ();
   logic [10:0]                  vcount;
   logic                         vblnk;
   logic [NUM_REQ-1:0]           req;
   logic [NUM_REQ-1:0]           done;
   logic [NUM_REQ-1:0]           gnt;
   logic                         window;
   logic                         frame_start;
   logic [15:0]                  frame_cnt;
   logic                         timeout;
   logic                         abort;
   logic [$clog2(NUM_REQ)-1:0]   timeout_id;
   logic [NUM_REQ-1:0]           missed;

   modport master (
      output vcount, vblnk, req, done,
      input  gnt, window, frame_start, frame_cnt, timeout, abort, timeout_id, missed
   );

   modport slave (
      input  vcount, vblnk, req, done,
      output gnt, window, frame_start, frame_cnt, timeout, abort, timeout_id, missed
   );
endinterface

// File: rtl/vblank_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible index after last_id, wrapping.
module rr_picker #(
   parameter  int NUM_REQ = 4,
   localparam int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] eligible_i,
   input  logic [IW-1:0]      last_id_i,
   output logic [NUM_REQ-1:0] winner_o,
   output logic [IW-1:0]      winner_id_o,
   output logic               any_o
);
   logic [IW-1:0]      cand_id [NUM_REQ];
   logic [NUM_REQ-1:0] cand_hit;

   // Candidate gi is the (gi+1)-th index after last_id; lower gi = higher priority.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [IW:0] sum;
      assign sum          = {1'b0, last_id_i} + (IW+1)'(gi + 1);
      assign cand_id[gi]  = (sum >= (IW+1)'(NUM_REQ)) ? IW'(sum - (IW+1)'(NUM_REQ))
                                                      : sum[IW-1:0];
      assign cand_hit[gi] = eligible_i[cand_id[gi]];
   end

   always_comb begin
      winner_id_o = '0;
      any_o       = |cand_hit;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (cand_hit[k]) begin
            winner_id_o = cand_id[k];
         end
      end
      winner_o = any_o ? (NUM_REQ'(1) << winner_id_o) : '0;
   end
endmodule

// File: rtl/vblank_arbiter.sv
// Opens an access window during vertical blanking and grants it round-robin,
// once per requester per frame, with per-grant timeout and close-of-window abort.
module vblank_arbiter
   import arb_pkg::*;
   import vga_pkg::*;
#(
   parameter int NUM_REQ          = NUM_REQ_DFLT,
   parameter int GUARD_LINES      = 2,
   parameter int MAX_GRANT_CYCLES = 4096
) (
   input  logic             clk,
   input  logic             rst_n,
   vblank_arbiter_if.slave  bus_io
);
   localparam int               IW       = $clog2(NUM_REQ);
   localparam int               CW       = $clog2(MAX_GRANT_CYCLES);
   localparam logic [10:0]      WIN_END  = 11'(VBLNK_END - GUARD_LINES);
   localparam logic [CW-1:0]    CNT_LAST = CW'(MAX_GRANT_CYCLES - 1);

   arb_state_t         state_q, state_d;
   logic               window_q, frame_start_q;
   logic [15:0]        frame_cnt_q;
   logic [NUM_REQ-1:0] served_q, served_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [IW-1:0]      gnt_id_q, gnt_id_d;
   logic [IW-1:0]      last_id_q, last_id_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               timeout_q, timeout_d;
   logic               abort_q, abort_d;
   logic [IW-1:0]      tid_q, tid_d;
   logic [NUM_REQ-1:0] missed_q;

   logic               win_c, win_rise, win_fall_c, done_hit;
   logic [NUM_REQ-1:0] eligible, winner;
   logic [IW-1:0]      winner_id;
   logic               any;

   assign win_c      = bus_io.vblnk && (bus_io.vcount < WIN_END);
   assign win_rise   = win_c && !window_q;
   assign win_fall_c = !win_c && window_q;
   assign eligible   = bus_io.req & ~served_q;
   assign done_hit   = |(bus_io.done & gnt_q);

   rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
      .eligible_i  (eligible),
      .last_id_i   (last_id_q),
      .winner_o    (winner),
      .winner_id_o (winner_id),
      .any_o       (any)
   );

   always_comb begin
      state_d   = state_q;
      served_d  = served_q;
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      last_id_d = last_id_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      abort_d   = 1'b0;
      tid_d     = tid_q;
      case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (frame_start_q) state_d = ARB;
         end
         ARB: begin
            // Don't start a grant in the last cycle before the window closes.
            if (!window_q) begin
               state_d = IDLE;
            end else if (any && win_c) begin
               state_d   = GRANT;
               gnt_d     = winner;
               gnt_id_d  = winner_id;
               last_id_d = winner_id;
               cnt_d     = '0;
            end
         end
         GRANT: begin
            cnt_d = cnt_q + CW'(1);
            if (done_hit) begin
               state_d  = ARB;
               gnt_d    = '0;
               served_d = served_q | gnt_q;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = ARB;
               gnt_d     = '0;
               served_d  = served_q | gnt_q;
               timeout_d = 1'b1;
               tid_d     = gnt_id_q;
            end else if (!window_q) begin
               state_d  = IDLE;
               gnt_d    = '0;
               served_d = served_q | gnt_q;
               abort_d  = 1'b1;
               tid_d    = gnt_id_q;
            end
         end
         default: state_d = IDLE;
      endcase
      if (win_rise) served_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         window_q      <= 1'b0;
         frame_start_q <= 1'b0;
         frame_cnt_q   <= '0;
         served_q      <= '0;
         gnt_q         <= '0;
         gnt_id_q      <= '0;
         last_id_q     <= IW'(NUM_REQ - 1);
         cnt_q         <= '0;
         timeout_q     <= 1'b0;
         abort_q       <= 1'b0;
         tid_q         <= '0;
         missed_q      <= '0;
      end else begin
         state_q       <= state_d;
         window_q      <= win_c;
         frame_start_q <= win_rise;
         if (win_rise) frame_cnt_q <= frame_cnt_q + 16'd1;
         served_q      <= served_d;
         gnt_q         <= gnt_d;
         gnt_id_q      <= gnt_id_d;
         last_id_q     <= last_id_d;
         cnt_q         <= cnt_d;
         timeout_q     <= timeout_d;
         abort_q       <= abort_d;
         tid_q         <= tid_d;
         missed_q      <= win_fall_c ? (bus_io.req & ~served_q & ~gnt_q) : '0;
      end
   end

   assign bus_io.gnt         = gnt_q;
   assign bus_io.window      = window_q;
   assign bus_io.frame_start = frame_start_q;
   assign bus_io.frame_cnt   = frame_cnt_q;
   assign bus_io.timeout     = timeout_q;
   assign bus_io.abort       = abort_q;
   assign bus_io.timeout_id  = tid_q;
   assign bus_io.missed      = missed_q;
endmodule

// File: tb/tb_vblank_arbiter.sv
// Scoreboard bench: each frame's expected grant sequence is queued when the frame
// is driven and checked as every grant ends.
`timescale 1ns/1ps
module tb_vblank_arbiter;
   import arb_pkg::*;

   localparam int LINE_CYC = 4;
   localparam int GAP_CYC  = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vblank_arbiter_if #(.NUM_REQ(4)) bus ();

   vblank_arbiter #(
      .NUM_REQ          (4),
      .GUARD_LINES      (2),
      .MAX_GRANT_CYCLES (16)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus)
   );

   typedef struct {
      int gnt;
      int delay;
      int len;
      int kind;   // 0 done, 1 timeout, 2 abort
      int id;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_bad = 0;

   int   cyc, ref_cyc, fall_cyc, start_cyc, cur_delay, gcnt;
   int   cur_gnt;
   logic [3:0] prev_gnt;
   logic prev_window;
   logic [3:0] frame_missed;
   bit   mon_en;
   int   done_mode;   // 0 after done_delay, 1 never, 2 when window drops
   int   done_delay;

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_chk++;
      if (obs != exp_v) begin
         n_bad++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   task automatic expect_grant(input int g, input int d, input int l, input int k, input int id);
      exp_t e;
      e.gnt = g; e.delay = d; e.len = l; e.kind = k; e.id = id;
      sb.push_back(e);
   endtask

   task automatic monitor();
      int kind;
      exp_t e;
      frame_missed |= bus.missed;
      if (bus.frame_start) ref_cyc = cyc;
      if (prev_window && !bus.window) fall_cyc = cyc;
      if (bus.gnt != 4'd0 && prev_gnt == 4'd0) begin
         start_cyc = cyc;
         cur_delay = cyc - ref_cyc;
         cur_gnt   = int'(bus.gnt);
      end
      if (bus.gnt == 4'd0 && prev_gnt != 4'd0) begin
         kind = bus.timeout ? 1 : (bus.abort ? 2 : 0);
         if (sb.size() == 0) begin
            chk("unexpected_grant", cur_gnt, 0);
         end else begin
            e = sb.pop_front();
            chk("gnt", cur_gnt, e.gnt);
            chk("onehot", $countones(cur_gnt), 1);
            chk("delay", cur_delay, e.delay);
            if (e.len >= 0) chk("len", cyc - start_cyc, e.len);
            chk("kind", kind, e.kind);
            if (e.kind != 0) chk("timeout_id", int'(bus.timeout_id), e.id);
            if (e.kind == 2) chk("abort_lag", cyc - fall_cyc, 1);
            $display("grant %b delay=%0d len=%0d kind=%0d", 4'(cur_gnt), cur_delay,
                     cyc - start_cyc, kind);
         end
         ref_cyc = cyc;
      end
   endtask

   task automatic respond();
      bus.done = '0;
      if (bus.gnt != 4'd0) begin
         gcnt++;
         if (done_mode == 0 && gcnt == done_delay + 1) bus.done = bus.gnt;
         if (done_mode == 2 && !bus.window) bus.done = bus.gnt;
      end else begin
         gcnt = 0;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      cyc++;
      if (mon_en) monitor();
      respond();
      prev_gnt    = bus.gnt;
      prev_window = bus.window;
   endtask

   task automatic do_reset();
      bus.vblnk = 1'b0; bus.vcount = '0; bus.req = '0; bus.done = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      sb.delete();
      prev_gnt = '0; prev_window = 1'b0; gcnt = 0;
      ref_cyc = cyc; fall_cyc = cyc; start_cyc = cyc; cur_delay = 0; cur_gnt = 0;
   endtask

   task automatic run_frame(input int first_line, input logic [3:0] r);
      bus.req = r;
      frame_missed = '0;
      for (int ln = first_line; ln <= 805; ln++) begin
         bus.vblnk  = 1'b1;
         bus.vcount = 11'(ln);
         repeat (LINE_CYC) cycle();
      end
      bus.vblnk  = 1'b0;
      bus.vcount = '0;
      repeat (GAP_CYC) cycle();
   endtask

   initial begin
      cyc = 0; mon_en = 1'b0; done_mode = 1; done_delay = 0;
      bus.vblnk = 1'b0; bus.vcount = '0; bus.req = '0; bus.done = '0;
      prev_gnt = '0; prev_window = 1'b0; frame_missed = '0;

      // Reset values while rst_n is held low
      #2;
      chk("rst_gnt", int'(bus.gnt), 0);
      chk("rst_window", int'(bus.window), 0);
      chk("rst_frame_start", int'(bus.frame_start), 0);
      chk("rst_frame_cnt", int'(bus.frame_cnt), 0);
      chk("rst_timeout", int'(bus.timeout), 0);
      chk("rst_abort", int'(bus.abort), 0);
      chk("rst_timeout_id", int'(bus.timeout_id), 0);
      chk("rst_missed", int'(bus.missed), 0);
      chk("rst_state", int'(dut.state_q), int'(IDLE));

      // Asynchronous reset in the middle of a grant
      do_reset();
      done_mode = 1;
      bus.req = 4'b0001; bus.vblnk = 1'b1; bus.vcount = 11'd768;
      for (int i = 0; i < 20 && bus.gnt == 4'd0; i++) cycle();
      chk("t1_gnt_seen", int'(bus.gnt), 1);
      repeat (3) cycle();
      rst_n = 1'b0;
      #1;
      chk("t1_async_gnt", int'(bus.gnt), 0);
      chk("t1_async_frame_cnt", int'(bus.frame_cnt), 0);
      chk("t1_async_window", int'(bus.window), 0);
      bus.vblnk = 1'b0; bus.vcount = '0; bus.req = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycle();
      chk("t1_state_idle", int'(dut.state_q), int'(IDLE));
      chk("t1_gnt_after", int'(bus.gnt), 0);
      $display("reset mid-grant done");

      mon_en = 1'b1;

      // Two requesters, done 10 cycles after each grant
      do_reset();
      done_mode = 0; done_delay = 10;
      expect_grant(4'b0001, 2, 11, 0, 0);
      expect_grant(4'b0100, 1, 11, 0, 0);
      run_frame(768, 4'b0101);
      chk("t2_frame_cnt", int'(bus.frame_cnt), 1);
      chk("t2_missed", int'(frame_missed), 0);
      chk("t2_sb_empty", sb.size(), 0);

      // Rotation across frames
      do_reset();
      expect_grant(4'b0001, 2, 11, 0, 0);
      run_frame(768, 4'b0001);
      expect_grant(4'b0010, 2, 11, 0, 0);
      expect_grant(4'b0001, 1, 11, 0, 0);
      run_frame(768, 4'b0011);
      chk("t3_frame_cnt", int'(bus.frame_cnt), 2);
      chk("t3_sb_empty", sb.size(), 0);

      // Timeout with no done
      do_reset();
      done_mode = 1;
      expect_grant(4'b0100, 2, 16, 1, 2);
      run_frame(768, 4'b0100);
      chk("t4_missed", int'(frame_missed), 0);
      chk("t4_sb_empty", sb.size(), 0);

      // Window closes under a grant, req[3] left waiting
      do_reset();
      done_mode = 1;
      expect_grant(4'b0001, 2, 11, 2, 0);
      run_frame(801, 4'b1001);
      chk("t5_missed", int'(frame_missed), 8);
      chk("t5_sb_empty", sb.size(), 0);

      // done coincides with the timeout limit
      do_reset();
      done_mode = 0; done_delay = 15;
      expect_grant(4'b0001, 2, 16, 0, 0);
      run_frame(768, 4'b0001);
      chk("t6a_served", int'(dut.served_q), 1);
      chk("t6a_sb_empty", sb.size(), 0);

      // done coincides with the window falling
      done_mode = 2;
      expect_grant(4'b0010, 2, 11, 0, 0);
      run_frame(801, 4'b0010);
      chk("t6b_served", int'(dut.served_q), 2);
      chk("t6b_missed", int'(frame_missed), 0);
      chk("t6b_frame_cnt", int'(bus.frame_cnt), 2);
      chk("t6b_sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
